// File: rtl/vend_pkg.sv
// Shared types, 7-segment encodings and helpers for the vending controller.
// Defining VEND_CANCEL_EN adds the CANCEL state to the state enum.
package vend_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StVend,
    StChange
`ifdef VEND_CANCEL_EN
    , StCancel
`endif
  } state_e;

  // Active-low segments a..g in bits 0..6, decimal point (bit 7) kept dark.
  localparam logic [7:0] Seg0     = 8'hC0;
  localparam logic [7:0] Seg1     = 8'hF9;
  localparam logic [7:0] Seg2     = 8'hA4;
  localparam logic [7:0] Seg3     = 8'hB0;
  localparam logic [7:0] Seg4     = 8'h99;
  localparam logic [7:0] Seg5     = 8'h92;
  localparam logic [7:0] Seg6     = 8'h82;
  localparam logic [7:0] Seg7     = 8'hF8;
  localparam logic [7:0] Seg8     = 8'h80;
  localparam logic [7:0] Seg9     = 8'h90;
  localparam logic [7:0] SegBlank = 8'hFF;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = Seg0;
      4'd1:    seg = Seg1;
      4'd2:    seg = Seg2;
      4'd3:    seg = Seg3;
      4'd4:    seg = Seg4;
      4'd5:    seg = Seg5;
      4'd6:    seg = Seg6;
      4'd7:    seg = Seg7;
      4'd8:    seg = Seg8;
      4'd9:    seg = Seg9;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter: one load cycle plus TOT_W shift cycles.
// A start pulse mid-conversion restarts from the new input.
module bcd_seq #(
  parameter int unsigned TOT_W  = 8,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [TOT_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int unsigned CntW = $clog2(TOT_W + 1);

  logic [TOT_W-1:0]    sh_q, sh_d;
  logic [4*DIGITS-1:0] work_q, work_d, adj;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                run_q, run_d;
  logic                done_q, done_d;

  always_comb begin
    adj = work_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end

    sh_d   = sh_q;
    work_d = work_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;

    if (start) begin
      sh_d   = bin;
      work_d = '0;
      cnt_d  = CntW'(TOT_W);
      run_d  = 1'b1;
    end else if (run_q) begin
      work_d = {adj[4*DIGITS-2:0], sh_q[TOT_W-1]};
      sh_d   = sh_q << 1;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      sh_q   <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      work_q <= work_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign bcd  = work_q;
  assign done = done_q;

endmodule

// File: rtl/vend_ctrl_seg.sv
// Coin-credit vending controller with change return and a multiplexed 7-segment credit display.
// Defining VEND_CANCEL_EN adds a cancel input that refunds the whole credit.
module vend_ctrl_seg
  import vend_pkg::*;
#(
  parameter int unsigned N_ITEMS = 4,
  parameter int unsigned TOT_W   = 8,
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned SCAN_W  = 16
) (
  input  logic                     sys_clk,
  input  logic                     reset,
`ifdef VEND_CANCEL_EN
  input  logic                     cancel,
`endif
  input  logic                     coin,
  input  logic [TOT_W-1:0]         coin_val,
  input  logic [N_ITEMS-1:0]       sel,
  input  logic [N_ITEMS*TOT_W-1:0] price,
  output logic [N_ITEMS-1:0]       dispense,
  output logic                     change_out,
  output logic                     coin_rej,
  output logic                     busy,
  output logic [7:0]               seg_out,
  output logic [DIGITS-1:0]        seg_sel
);

  localparam int unsigned DigW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e               state_q, state_d;
  logic [TOT_W-1:0]     tot_q, tot_d, tot_seen_q;
  logic [2:0]           k_q, k_d;
  logic [N_ITEMS-1:0]   dispense_q, dispense_d;
  logic                 change_q, change_d;
  logic                 rej_q, rej_d;
  logic                 busy_q, busy_d;
  logic [SCAN_W-1:0]    scan_q, scan_d;
  logic [DigW-1:0]      dig_q, dig_d;
  logic [7:0]           seg_out_q, seg_out_d;
  logic [DIGITS-1:0]    seg_sel_q, seg_sel_d;
  logic [4*DIGITS-1:0]  disp_q, disp_d;

  logic [TOT_W:0]       sum;
  logic [TOT_W-1:0]     tot_add, price_sel, price_k;
  logic [2:0]           k_low;
  logic                 changing;
  logic                 blank;
  logic [4*DIGITS-1:0]  conv_bcd;
  logic                 conv_done;

  always_comb begin
    k_low     = lowest_set(8'(sel));
    price_sel = price[int'(k_low)*TOT_W +: TOT_W];
    price_k   = price[int'(k_q)*TOT_W +: TOT_W];
    sum       = {1'b0, tot_q} + {1'b0, coin_val};
    tot_add   = tot_q;
    if (coin) tot_add = sum[TOT_W] ? '1 : sum[TOT_W-1:0];

    state_d = state_q;
    tot_d   = tot_q;
    k_d     = k_q;
    rej_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        tot_d = tot_add;
        rej_d = coin && sum[TOT_W];
`ifdef VEND_CANCEL_EN
        if (cancel && (tot_add != '0)) begin
          state_d = StCancel;
        end else
`endif
        // Affordability uses the credit held before any same-cycle coin.
        if ((|sel) && (tot_q >= price_sel)) begin
          state_d = StVend;
          k_d     = k_low;
        end
      end
      StVend: begin
        rej_d   = coin;
        tot_d   = (tot_q >= price_k) ? (tot_q - price_k) : '0;
        state_d = (tot_d != '0) ? StChange : StIdle;
      end
`ifdef VEND_CANCEL_EN
      StChange, StCancel: begin
`else
      StChange: begin
`endif
        rej_d = coin;
        if (tot_q != '0) tot_d = tot_q - 1'b1;
        if (tot_q <= TOT_W'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef VEND_CANCEL_EN
    changing = (state_d == StChange) || (state_d == StCancel);
`else
    changing = (state_d == StChange);
`endif
    // Output flops take the next state's action so pulses line up with the state.
    change_d = changing && (tot_d != '0);
    busy_d   = (state_d != StIdle);
    for (int i = 0; i < int'(N_ITEMS); i++) begin
      dispense_d[i] = (state_d == StVend) && (k_d == 3'(i));
    end
  end

  always_comb begin
    disp_d = conv_done ? conv_bcd : disp_q;
    scan_d = scan_q + 1'b1;
    dig_d  = dig_q;
    if (scan_q == '1) dig_d = (dig_q == DigW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;

    blank     = (dig_d != '0) && ((disp_q >> (4 * int'(dig_d))) == '0);
    seg_out_d = blank ? SegBlank : seg_encode(disp_q[int'(dig_d)*4 +: 4]);
    seg_sel_d = ~(DIGITS'(1) << dig_d);
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      tot_q      <= '0;
      tot_seen_q <= '0;
      k_q        <= '0;
      dispense_q <= '0;
      change_q   <= 1'b0;
      rej_q      <= 1'b0;
      busy_q     <= 1'b0;
      scan_q     <= '0;
      dig_q      <= '0;
      seg_out_q  <= SegBlank;
      seg_sel_q  <= '1;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      tot_q      <= tot_d;
      tot_seen_q <= tot_q;
      k_q        <= k_d;
      dispense_q <= dispense_d;
      change_q   <= change_d;
      rej_q      <= rej_d;
      busy_q     <= busy_d;
      scan_q     <= scan_d;
      dig_q      <= dig_d;
      seg_out_q  <= seg_out_d;
      seg_sel_q  <= seg_sel_d;
      disp_q     <= disp_d;
    end
  end

  bcd_seq #(
    .TOT_W  (TOT_W),
    .DIGITS (DIGITS)
  ) u_bcd_seq (
    .sys_clk (sys_clk),
    .reset   (reset),
    .start   (tot_q != tot_seen_q),
    .bin     (tot_q),
    .bcd     (conv_bcd),
    .done    (conv_done)
  );

  assign dispense   = dispense_q;
  assign change_out = change_q;
  assign coin_rej   = rej_q;
  assign busy       = busy_q;
  assign seg_out    = seg_out_q;
  assign seg_sel    = seg_sel_q;

endmodule

// File: tb/tb_vend_ctrl_seg.sv
// Directed bench for vend_ctrl_seg: vend/change, refusal, saturation, reset abort and display.
// The cancel scenario is compiled in when VEND_CANCEL_EN is defined.
module tb_vend_ctrl_seg;

  localparam int unsigned NItems = 4;
  localparam int unsigned TotW   = 8;
  localparam int unsigned Digits = 4;
  localparam int unsigned ScanW  = 2;

  logic                     sys_clk = 1'b0;
  logic                     reset   = 1'b0;
  logic                     coin    = 1'b0;
  logic [TotW-1:0]          coin_val = '0;
  logic [NItems-1:0]        sel     = '0;
  logic [NItems*TotW-1:0]   price;
  logic [NItems-1:0]        dispense;
  logic                     change_out;
  logic                     coin_rej;
  logic                     busy;
  logic [7:0]               seg_out;
  logic [Digits-1:0]        seg_sel;
`ifdef VEND_CANCEL_EN
  logic                     cancel = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_chg    = 0;
  int n_disp   = 0;
  int n_rej    = 0;

  // item3=200, item2=0, item1=60, item0=70
  assign price = {8'd200, 8'd0, 8'd60, 8'd70};

  vend_ctrl_seg #(
    .N_ITEMS (NItems),
    .TOT_W   (TotW),
    .DIGITS  (Digits),
    .SCAN_W  (ScanW)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
`ifdef VEND_CANCEL_EN
    .cancel     (cancel),
`endif
    .coin       (coin),
    .coin_val   (coin_val),
    .sel        (sel),
    .price      (price),
    .dispense   (dispense),
    .change_out (change_out),
    .coin_rej   (coin_rej),
    .busy       (busy),
    .seg_out    (seg_out),
    .seg_sel    (seg_sel)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (change_out) n_chg <= n_chg + 1;
    if (|dispense)  n_disp <= n_disp + 1;
    if (coin_rej)   n_rej <= n_rej + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic coin_in(input logic [TotW-1:0] v);
    coin = 1'b1;
    coin_val = v;
    step();
    coin = 1'b0;
    coin_val = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) step();
    check_eq(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_digit(input string tag, input int d, input logic [7:0] exp);
    logic [3:0] want;
    want = ~(4'b0001 << d);
    for (int i = 0; i < 40 && seg_sel !== want; i++) step();
    check_eq({tag, "_sel"}, {28'd0, seg_sel}, {28'd0, want});
    check_eq(tag, {24'd0, seg_out}, {24'd0, exp});
  endtask

  task automatic show_check(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    repeat (TotW + 4) step();
    check_digit({tag, "_d0"}, 0, e0);
    check_digit({tag, "_d1"}, 1, e1);
    check_digit({tag, "_d2"}, 2, e2);
    check_digit({tag, "_d3"}, 3, e3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0, r0, seen;

    // Reset state
    reset = 1'b0;
    step();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_disp", {28'd0, dispense}, 32'd0);
    check_eq("rst_chg", {31'd0, change_out}, 32'd0);
    check_eq("rst_rej", {31'd0, coin_rej}, 32'd0);
    check_eq("rst_sel", {28'd0, seg_sel}, 32'hF);
    check_eq("rst_tot", {24'd0, dut.tot_q}, 32'd0);
    reset = 1'b1;
    step();
    check_eq("rel_sel", {28'd0, seg_sel}, 32'hE);
    check_eq("rel_seg", {24'd0, seg_out}, 32'hC0);

    // 50+50, item0 at 70 -> one vend, 30 change
    c0 = n_chg; d0 = n_disp;
    coin_in(8'd50);
    coin_in(8'd50);
    check_eq("a_tot", {24'd0, dut.tot_q}, 32'd100);
    sel = 4'b0001;
    step();
    sel = 4'b0000;
    check_eq("a_disp", {28'd0, dispense}, 32'b0001);
    check_eq("a_busy", {31'd0, busy}, 32'd1);
    wait_idle("a_idle", 200);
    check_eq("a_nchg", n_chg - c0, 32'd30);
    check_eq("a_ndisp", n_disp - d0, 32'd1);
    check_eq("a_tot0", {24'd0, dut.tot_q}, 32'd0);

    // 40 < 60: no vend; +20 with sel held -> exact vend
    c0 = n_chg; d0 = n_disp;
    coin_in(8'd20);
    coin_in(8'd20);
    sel = 4'b0010;
    repeat (3) step();
    check_eq("b_nodisp", n_disp - d0, 32'd0);
    check_eq("b_busy", {31'd0, busy}, 32'd0);
    check_eq("b_tot", {24'd0, dut.tot_q}, 32'd40);
    show_check("b_show40", 8'hC0, 8'h99, 8'hFF, 8'hFF);
    coin_in(8'd20);
    check_eq("b_tot60", {24'd0, dut.tot_q}, 32'd60);
    step();
    sel = 4'b0000;
    check_eq("b_disp", {28'd0, dispense}, 32'b0010);
    wait_idle("b_idle", 50);
    check_eq("b_nchg", n_chg - c0, 32'd0);
    check_eq("b_ndisp", n_disp - d0, 32'd1);
    check_eq("b_tot0", {24'd0, dut.tot_q}, 32'd0);

    // Saturation: 250 + 10 -> 255 and one reject
    coin_in(8'd200);
    coin_in(8'd50);
    check_eq("c_tot250", {24'd0, dut.tot_q}, 32'd250);
    r0 = n_rej;
    coin_in(8'd10);
    check_eq("c_rej", {31'd0, coin_rej}, 32'd1);
    check_eq("c_tot255", {24'd0, dut.tot_q}, 32'd255);
    step();
    check_eq("c_rej_off", {31'd0, coin_rej}, 32'd0);
    check_eq("c_nrej", n_rej - r0, 32'd1);
    show_check("c_show255", 8'h92, 8'h92, 8'hA4, 8'hFF);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_eq("c_clr", {24'd0, dut.tot_q}, 32'd0);

    // Coin during CHANGE is refused and does not alter the change count
    c0 = n_chg; r0 = n_rej;
    coin_in(8'd100);
    sel = 4'b0001;
    step();
    sel = 4'b0000;
    repeat (5) step();
    coin_in(8'd50);
    check_eq("d_rej", {31'd0, coin_rej}, 32'd1);
    check_eq("d_busy", {31'd0, busy}, 32'd1);
    wait_idle("d_idle", 200);
    check_eq("d_nchg", n_chg - c0, 32'd30);
    check_eq("d_nrej", n_rej - r0, 32'd1);
    check_eq("d_tot0", {24'd0, dut.tot_q}, 32'd0);

    // Reset on the 3rd change pulse aborts the refund
    c0 = n_chg;
    seen = 0;
    coin_in(8'd100);
    sel = 4'b0001;
    step();
    sel = 4'b0000;
    for (int i = 0; i < 50 && seen < 3; i++) begin
      step();
      if (change_out) seen++;
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (40) step();
    check_eq("e_nchg", n_chg - c0, 32'd3);
    check_eq("e_busy", {31'd0, busy}, 32'd0);
    check_eq("e_tot0", {24'd0, dut.tot_q}, 32'd0);
    show_check("e_show0", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // Zero-price item vends with zero credit and no change
    c0 = n_chg;
    sel = 4'b0100;
    step();
    sel = 4'b0000;
    check_eq("f_disp", {28'd0, dispense}, 32'b0100);
    step();
    check_eq("f_busy", {31'd0, busy}, 32'd0);
    check_eq("f_disp_off", {28'd0, dispense}, 32'd0);
    check_eq("f_nchg", n_chg - c0, 32'd0);

`ifdef VEND_CANCEL_EN
    // Cancel beats a same-cycle affordable sel and refunds everything
    c0 = n_chg; d0 = n_disp;
    coin_in(8'd25);
    cancel = 1'b1;
    sel = 4'b0100;
    step();
    cancel = 1'b0;
    sel = 4'b0000;
    wait_idle("g_idle", 100);
    check_eq("g_nchg", n_chg - c0, 32'd25);
    check_eq("g_ndisp", n_disp - d0, 32'd0);
    check_eq("g_tot0", {24'd0, dut.tot_q}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
